// File: rtl/fetch_stage_pkg.sv
// Shared constants for the fetch front end: opcodes, the NOP bubble encoding and fetch FSM states.
package fetch_stage_pkg;

  localparam logic [4:0]  OPC_HALT      = 5'b00000;
  localparam logic [4:0]  OPC_NOP       = 5'b00001;
  localparam logic [15:0] NOP_INSTR_ENC = {OPC_NOP, 11'b0};

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_t;

  // Instructions are halfword aligned; bit 0 of any target is dropped.
  function automatic logic [15:0] align_pc(input logic [15:0] pc);
    return {pc[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Pipeline latch carrying instruction, PC+2 and valid; flush forces a NOP bubble and wins over load.
// One cycle from inputs to outputs; contents hold while neither load nor flush is asserted.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_ENC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [15:0] instr,
  input  logic [15:0] pc_plus2,
  output logic [15:0] id_instr,
  output logic [15:0] id_pc_plus2,
  output logic        id_valid
);

  // A bubble keeps the previous PC+2; decode ignores it when id_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_instr    <= NOP_INSTR;
      id_pc_plus2 <= 16'h0000;
      id_valid    <= 1'b0;
    end else if (flush) begin
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else if (load) begin
      id_instr    <= instr;
      id_pc_plus2 <= pc_plus2;
      id_valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, IF/ID register, redirect/stall/HALT handling; one cycle imem_addr -> id_instr,
// stall holds everything, redirect overrides stall. FETCH_PERF_CNT_EN adds saturating fetch/flush counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_ENC,
  parameter logic [4:0]  HALT_OPC  = OPC_HALT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  output logic [15:0] id_instr,
  output logic [15:0] id_pc_plus2,
  output logic        id_valid,
  output logic        halted,
  output logic        err,
  output logic [15:0] fetch_cnt,
  output logic [15:0] flush_cnt
);

  fetch_state_t state, state_next;
  logic [15:0]  pc, pc_next, pc_plus2;
  logic         ifid_load, ifid_flush;

  assign pc_plus2  = pc + 16'd2;
  assign imem_addr = pc;
  assign halted    = (state == ST_HALTED);
  assign err       = redirect_en & redirect_pc[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= RESET_PC;
      state <= ST_RUN;
    end else begin
      pc    <= pc_next;
      state <= state_next;
    end
  end

  always_comb begin
    pc_next    = pc;
    state_next = state;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    if (redirect_en) begin
      pc_next    = align_pc(redirect_pc);
      state_next = ST_RUN;
      ifid_flush = 1'b1;
    end else if (!stall) begin
      case (state)
        ST_RUN: begin
          ifid_load = 1'b1;
          // HALT is still delivered to decode, but the PC parks on it.
          if (imem_data[15:11] == HALT_OPC) state_next = ST_HALTED;
          else                              pc_next    = pc_plus2;
        end
        ST_HALTED: ifid_flush = 1'b1;
        default:   state_next = ST_RUN;
      endcase
    end
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk         (clk),
    .rst         (rst),
    .load        (ifid_load),
    .flush       (ifid_flush),
    .instr       (imem_data),
    .pc_plus2    (pc_plus2),
    .id_instr    (id_instr),
    .id_pc_plus2 (id_pc_plus2),
    .id_valid    (id_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= 16'h0000;
      flush_cnt <= 16'h0000;
    end else begin
      if (ifid_load && fetch_cnt != 16'hFFFF)   fetch_cnt <= fetch_cnt + 16'd1;
      if (redirect_en && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`else
  assign fetch_cnt = 16'h0000;
  assign flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage against a combinational instruction memory model.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall;
  logic        redirect_en;
  logic [15:0] redirect_pc;
  logic [15:0] id_instr;
  logic [15:0] id_pc_plus2;
  logic        id_valid;
  logic        halted;
  logic        err;
  logic [15:0] fetch_cnt;
  logic [15:0] flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [15:0] HALT_ADDR = 16'h0020;

  // Every word is a NOP-opcode with its word index in the low bits, except a HALT at HALT_ADDR.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a == HALT_ADDR) ? 16'h0000 : {5'b00001, a[11:1]};
  endfunction

  assign imem_data = mem_word(imem_addr);

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .stall       (stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .id_instr    (id_instr),
    .id_pc_plus2 (id_pc_plus2),
    .id_valid    (id_valid),
    .halted      (halted),
    .err         (err),
    .fetch_cnt   (fetch_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %04h expected %04h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_id(input string tag, input logic [15:0] addr, input logic [15:0] instr,
                          input logic [15:0] ppc2, input logic valid);
    check({tag, ".addr"},  imem_addr, addr);
    check({tag, ".instr"}, id_instr, instr);
    check({tag, ".ppc2"},  id_pc_plus2, ppc2);
    check({tag, ".valid"}, {15'b0, id_valid}, {15'b0, valid});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = 16'h0000;
    #2;
    check_id("reset", 16'h0000, 16'h0800, 16'h0000, 1'b0);
    check("reset.halted", {15'b0, halted}, 16'h0000);
    check("reset.err",    {15'b0, err},    16'h0000);
    check("reset.fcnt",   fetch_cnt, 16'h0000);
    check("reset.rcnt",   flush_cnt, 16'h0000);
    #10 rst = 1'b0;

    // Sequential fetch from reset.
    tick(); check_id("seq0", 16'h0002, 16'h0800, 16'h0002, 1'b1);
    tick(); check_id("seq1", 16'h0004, 16'h0801, 16'h0004, 1'b1);
    tick(); check_id("seq2", 16'h0006, 16'h0802, 16'h0006, 1'b1);

    // Stall holds PC and IF/ID.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); check_id("stall", 16'h0006, 16'h0802, 16'h0006, 1'b1);
    end
    stall = 1'b0;
    tick(); check_id("unstall", 16'h0008, 16'h0803, 16'h0008, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    check("at10", imem_addr, 16'h0010);

    // Redirect beats a simultaneous stall.
    redirect_en = 1'b1; redirect_pc = 16'h0040; stall = 1'b1;
    #1 check("redir.err", {15'b0, err}, 16'h0000);
    tick(); check("redir.valid", {15'b0, id_valid}, 16'h0000);
    check("redir.instr", id_instr, 16'h0800);
    check("redir.addr",  imem_addr, 16'h0040);
    redirect_en = 1'b0; stall = 1'b0;
    tick(); check_id("redir.tgt", 16'h0042, 16'h0820, 16'h0042, 1'b1);

    // HALT: delivered once, then bubbles with PC parked until redirect.
    redirect_en = 1'b1; redirect_pc = 16'h001E;
    tick(); redirect_en = 1'b0;
    tick(); check_id("pre_halt", 16'h0020, 16'h080F, 16'h0020, 1'b1);
    tick(); check_id("halt", 16'h0020, 16'h0000, 16'h0022, 1'b1);
    check("halt.halted", {15'b0, halted}, 16'h0001);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("halted.addr",  imem_addr, 16'h0020);
      check("halted.valid", {15'b0, id_valid}, 16'h0000);
      check("halted.instr", id_instr, 16'h0800);
      check("halted.flag",  {15'b0, halted}, 16'h0001);
    end
    redirect_en = 1'b1; redirect_pc = 16'h0030;
    tick(); redirect_en = 1'b0;
    check("unhalt.flag",  {15'b0, halted}, 16'h0000);
    check("unhalt.addr",  imem_addr, 16'h0030);
    check("unhalt.valid", {15'b0, id_valid}, 16'h0000);
    tick(); check_id("resume", 16'h0032, 16'h0818, 16'h0032, 1'b1);

    // PC wraps modulo 2^16.
    redirect_en = 1'b1; redirect_pc = 16'hFFFE;
    tick(); redirect_en = 1'b0;
    check("wrap.addr0", imem_addr, 16'hFFFE);
    tick(); check_id("wrap", 16'h0000, 16'h0FFF, 16'h0000, 1'b1);

    // Misaligned target: err flagged, bit 0 dropped.
    redirect_en = 1'b1; redirect_pc = 16'h0041;
    #1 check("mis.err", {15'b0, err}, 16'h0001);
    tick(); check("mis.addr", imem_addr, 16'h0040);
    redirect_en = 1'b0;
    #1 check("mis.err_clr", {15'b0, err}, 16'h0000);

    // Fresh run for counters: 10 deliveries, then 2 redirects.
    rst = 1'b1; #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    redirect_en = 1'b1; redirect_pc = 16'h0100;
    tick(); tick();
    redirect_en = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    check("cnt.fetch", fetch_cnt, 16'd10);
    check("cnt.flush", flush_cnt, 16'd2);
`else
    check("cnt.fetch", fetch_cnt, 16'h0000);
    check("cnt.flush", flush_cnt, 16'h0000);
`endif
    tick(); tick();
    check("pre_rst.valid", {15'b0, id_valid}, 16'h0001);

    // Reset mid-cycle takes effect without a clock edge.
    #2 rst = 1'b1;
    #1;
    check_id("arst", 16'h0000, 16'h0800, 16'h0000, 1'b0);
    check("arst.fcnt", fetch_cnt, 16'h0000);
    check("arst.rcnt", flush_cnt, 16'h0000);
    check("arst.halted", {15'b0, halted}, 16'h0000);
    #1 rst = 1'b0;
    tick(); check_id("post_arst", 16'h0002, 16'h0800, 16'h0002, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
